// File: rtl/fp_pkg.sv
// Shared FP32 constants, the unpacked operand struct and the operand unpack helper.
package fp_pkg;

    localparam int EXP_WIDTH          = 8;
    localparam int SIGNIFICANDS_WIDTH = 23;
    localparam int DATA_WIDTH         = 32;
    localparam int ALIGN_WIDTH        = 27;
    localparam int SIG_WIDTH          = SIGNIFICANDS_WIDTH + 1;

    localparam logic [EXP_WIDTH-1:0] EXP_MAX = 8'hFF;

    typedef struct packed {
        logic                 sign;
        logic [EXP_WIDTH-1:0] exp;
        logic [SIG_WIDTH-1:0] sig;
    } fp_op_t;

    // The hidden bit is 0 for denormals; exp is kept raw so it can be compared as-is.
    function automatic fp_op_t unpack_op(input logic [DATA_WIDTH-1:0] op);
        fp_op_t u;
        u.sign = op[DATA_WIDTH-1];
        u.exp  = op[DATA_WIDTH-2 -: EXP_WIDTH];
        u.sig  = {(op[DATA_WIDTH-2 -: EXP_WIDTH] != '0), op[SIGNIFICANDS_WIDTH-1:0]};
        return u;
    endfunction

    function automatic logic [EXP_WIDTH-1:0] eff_exp(input logic [EXP_WIDTH-1:0] e);
        return (e == '0) ? {{(EXP_WIDTH-1){1'b0}}, 1'b1} : e;
    endfunction

endpackage

// File: rtl/fp_align_shift.sv
// Combinational right shifter for the smaller significand, appending G/R/S positions.
// FP_ALIGN_STICKY_EN: when defined, the LSB collects the OR of every bit shifted out.
module fp_align_shift #(
    parameter int SIG_WIDTH   = 24,
    parameter int SHIFT_WIDTH = 8,
    parameter int ALIGN_WIDTH = 27
) (
    input  logic [SIG_WIDTH-1:0]   sig_in,
    input  logic [SHIFT_WIDTH-1:0] shamt,
    output logic [ALIGN_WIDTH-1:0] sig_out
);

    logic [ALIGN_WIDTH-1:0] ext;
    logic [ALIGN_WIDTH-1:0] shifted;

    assign ext     = {sig_in, {(ALIGN_WIDTH-SIG_WIDTH){1'b0}}};
    assign shifted = ext >> shamt;

`ifdef FP_ALIGN_STICKY_EN
    logic [ALIGN_WIDTH-1:0] lost_mask;
    logic                   sticky;

    // Shifts of ALIGN_WIDTH or more make the mask all ones, so sticky becomes |sig_in.
    assign lost_mask = ~({ALIGN_WIDTH{1'b1}} << shamt);
    assign sticky    = |(ext & lost_mask);
    assign sig_out   = {shifted[ALIGN_WIDTH-1:1], shifted[0] | sticky};
`else
    assign sig_out   = shifted;
`endif

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage FP32 operand alignment: swap so the larger magnitude leads, then align the smaller.
// FP_ALIGN_STICKY_EN selects sticky generation in the stage-2 shifter.
module fp_align_stage #(
    parameter int EXP_WIDTH          = 8,
    parameter int SIGNIFICANDS_WIDTH = 23,
    parameter int DATA_WIDTH         = 32,
    parameter int ALIGN_WIDTH        = 27
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  op_a,
    input  logic [DATA_WIDTH-1:0]  op_b,
    input  logic                   sig2_ge_sig1,
    input  logic                   sub_op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ALIGN_WIDTH-1:0] big_sig,
    output logic [ALIGN_WIDTH-1:0] small_sig,
    output logic [EXP_WIDTH-1:0]   res_exp,
    output logic                   res_sign,
    output logic                   eff_sub,
    output logic                   swapped,
    output logic                   special
);

    import fp_pkg::*;

    localparam int SW = SIGNIFICANDS_WIDTH + 1;

    fp_op_t a_u, b_u, big_u, small_u;
    logic   swap;
    logic   en1, en2;

    logic                 s1_valid, s2_valid;
    logic [SW-1:0]        s1_big_sig, s1_small_sig;
    logic [EXP_WIDTH-1:0] s1_d, s1_res_exp;
    logic                 s1_res_sign, s1_eff_sub, s1_swapped, s1_special;

    logic [ALIGN_WIDTH-1:0] small_aligned;

    assign a_u     = unpack_op(op_a);
    assign b_u     = unpack_op(op_b);
    assign swap    = (b_u.exp > a_u.exp) | ((b_u.exp == a_u.exp) & sig2_ge_sig1);
    assign big_u   = swap ? b_u : a_u;
    assign small_u = swap ? a_u : b_u;

    assign en2      = out_ready | ~s2_valid;
    assign en1      = en2 | ~s1_valid;
    assign in_ready = en1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_big_sig   <= '0;
            s1_small_sig <= '0;
            s1_d         <= '0;
            s1_res_exp   <= '0;
            s1_res_sign  <= 1'b0;
            s1_eff_sub   <= 1'b0;
            s1_swapped   <= 1'b0;
            s1_special   <= 1'b0;
        end else begin
            if (en1) s1_valid <= in_valid;
            if (en1 && in_valid) begin
                s1_big_sig   <= big_u.sig;
                s1_small_sig <= small_u.sig;
                s1_d         <= eff_exp(big_u.exp) - eff_exp(small_u.exp);
                s1_res_exp   <= big_u.exp;
                s1_res_sign  <= swap ? (b_u.sign ^ sub_op) : a_u.sign;
                s1_eff_sub   <= a_u.sign ^ b_u.sign ^ sub_op;
                s1_swapped   <= swap;
                s1_special   <= (a_u.exp == EXP_MAX) | (b_u.exp == EXP_MAX);
            end
        end
    end

    fp_align_shift #(
        .SIG_WIDTH   (SW),
        .SHIFT_WIDTH (EXP_WIDTH),
        .ALIGN_WIDTH (ALIGN_WIDTH)
    ) u_shift (
        .sig_in  (s1_small_sig),
        .shamt   (s1_d),
        .sig_out (small_aligned)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid  <= 1'b0;
            big_sig   <= '0;
            small_sig <= '0;
            res_exp   <= '0;
            res_sign  <= 1'b0;
            eff_sub   <= 1'b0;
            swapped   <= 1'b0;
            special   <= 1'b0;
        end else begin
            if (en2) s2_valid <= s1_valid;
            if (en2 && s1_valid) begin
                big_sig   <= {s1_big_sig, {(ALIGN_WIDTH-SW){1'b0}}};
                small_sig <= small_aligned;
                res_exp   <= s1_res_exp;
                res_sign  <= s1_res_sign;
                eff_sub   <= s1_eff_sub;
                swapped   <= s1_swapped;
                special   <= s1_special;
            end
        end
    end

    assign out_valid = s2_valid;

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed self-checking bench for fp_align_stage; expected values are hand-computed.
module tb_fp_align_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a, op_b;
    logic        sig2_ge_sig1;
    logic        sub_op;
    logic        out_valid;
    logic        out_ready;
    logic [26:0] big_sig, small_sig;
    logic [7:0]  res_exp;
    logic        res_sign, eff_sub, swapped, special;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fp_align_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .sig2_ge_sig1 (sig2_ge_sig1),
        .sub_op       (sub_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .big_sig      (big_sig),
        .small_sig    (small_sig),
        .res_exp      (res_exp),
        .res_sign     (res_sign),
        .eff_sub      (eff_sub),
        .swapped      (swapped),
        .special      (special)
    );

    // Presents one pair for a single cycle; returns at the negedge where the result should be visible.
    task automatic drive_pair(input logic [31:0] a, input logic [31:0] b,
                              input logic sub, input logic ge);
        @(negedge clk);
        op_a = a; op_b = b; sub_op = sub; sig2_ge_sig1 = ge; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        op_a = '0; op_b = '0; sub_op = 1'b0; sig2_ge_sig1 = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_checks++;
        if (big_sig !== 27'h0 || small_sig !== 27'h0 || res_exp !== 8'h0)
            begin n_fail++; $display("FAIL reset_data got %h/%h/%h want 0/0/0", big_sig, small_sig, res_exp); end
        rst_n = 1'b1;
    endtask

    task automatic test_equal_ops();
        drive_pair(32'h3F800000, 32'h3F800000, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL eq_latency got out_valid=%b want 1", out_valid); end
        n_checks++;
        if (swapped !== 1'b1 || res_exp !== 8'h7F || eff_sub !== 1'b0 || res_sign !== 1'b0)
            begin n_fail++; $display("FAIL eq_fields got sw=%b exp=%h es=%b rs=%b want 1/7f/0/0", swapped, res_exp, eff_sub, res_sign); end
        n_checks++;
        if (big_sig !== 27'h4000000 || small_sig !== 27'h4000000)
            begin n_fail++; $display("FAIL eq_sigs got %h/%h want 4000000/4000000", big_sig, small_sig); end
    endtask

    task automatic test_shift_one();
        drive_pair(32'h3F800000, 32'h40000000, 1'b0, 1'b1);
        n_checks++;
        if (out_valid !== 1'b1 || swapped !== 1'b1 || res_exp !== 8'h80)
            begin n_fail++; $display("FAIL shift1_fields got v=%b sw=%b exp=%h want 1/1/80", out_valid, swapped, res_exp); end
        n_checks++;
        if (big_sig !== 27'h4000000 || small_sig !== 27'h2000000)
            begin n_fail++; $display("FAIL shift1_sigs got %h/%h want 4000000/2000000", big_sig, small_sig); end
    endtask

    task automatic test_large_shift();
        logic [26:0] exp_small;
`ifdef FP_ALIGN_STICKY_EN
        exp_small = 27'h0000001;
`else
        exp_small = 27'h0000000;
`endif
        drive_pair(32'h3F800000, 32'h4E800000, 1'b0, 1'b1);
        n_checks++;
        if (small_sig !== exp_small || res_exp !== 8'h9D || swapped !== 1'b1)
            begin n_fail++; $display("FAIL shift30 got small=%h exp=%h sw=%b want %h/9d/1", small_sig, res_exp, swapped, exp_small); end
    endtask

    task automatic test_signs();
        drive_pair(32'hBF800000, 32'h3F000000, 1'b0, 1'b1);
        n_checks++;
        if (swapped !== 1'b0 || eff_sub !== 1'b1 || res_sign !== 1'b1 || res_exp !== 8'h7F)
            begin n_fail++; $display("FAIL signs_fields got sw=%b es=%b rs=%b exp=%h want 0/1/1/7f", swapped, eff_sub, res_sign, res_exp); end
        n_checks++;
        if (small_sig !== 27'h2000000 || big_sig !== 27'h4000000)
            begin n_fail++; $display("FAIL signs_sigs got %h/%h want 4000000/2000000", big_sig, small_sig); end
        // 1.0 - 1.0: tie swaps, so result sign is sign_b ^ sub_op.
        drive_pair(32'h3F800000, 32'h3F800000, 1'b1, 1'b1);
        n_checks++;
        if (eff_sub !== 1'b1 || res_sign !== 1'b1 || swapped !== 1'b1)
            begin n_fail++; $display("FAIL sub_op got es=%b rs=%b sw=%b want 1/1/1", eff_sub, res_sign, swapped); end
    endtask

    task automatic test_special();
        drive_pair(32'h7F800000, 32'h3F800000, 1'b0, 1'b0);
        n_checks++;
        if (special !== 1'b1 || swapped !== 1'b0 || res_exp !== 8'hFF)
            begin n_fail++; $display("FAIL special got sp=%b sw=%b exp=%h want 1/0/ff", special, swapped, res_exp); end
        drive_pair(32'h3F800000, 32'h40000000, 1'b0, 1'b1);
        n_checks++;
        if (special !== 1'b0) begin n_fail++; $display("FAIL special_clear got %b want 0", special); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] b_ops   [4] = '{32'h40000000, 32'h40800000, 32'h41000000, 32'h41800000};
        logic [7:0]  exp_exp [4] = '{8'h80, 8'h81, 8'h82, 8'h83};
        logic [26:0] exp_sm  [4] = '{27'h2000000, 27'h1000000, 27'h0800000, 27'h0400000};
        int sent = 0, rcvd = 0, stall = 0, full_seen = 0;
        bit first_seen = 0;
        for (int cyc = 0; cyc < 40 && rcvd < 4; cyc++) begin
            @(negedge clk);
            if (out_valid && !first_seen) begin first_seen = 1; stall = 3; end
            out_ready = (stall == 0);
            if (stall > 0) stall--;
            in_valid = (sent < 4);
            op_a = 32'h3F800000; op_b = (sent < 4) ? b_ops[sent] : 32'h0;
            sub_op = 1'b0; sig2_ge_sig1 = 1'b1;
            #1;
            if (out_valid && !out_ready && !in_ready) full_seen++;
            if (out_valid && !out_ready) begin
                n_checks++;
                if (res_exp !== exp_exp[rcvd] || small_sig !== exp_sm[rcvd])
                    begin n_fail++; $display("FAIL b2b_hold got %h/%h want %h/%h", res_exp, small_sig, exp_exp[rcvd], exp_sm[rcvd]); end
            end
            if (out_valid && out_ready) begin
                n_checks++;
                if (res_exp !== exp_exp[rcvd] || small_sig !== exp_sm[rcvd] || swapped !== 1'b1)
                    begin n_fail++; $display("FAIL b2b_result%0d got %h/%h sw=%b want %h/%h sw=1", rcvd, res_exp, small_sig, swapped, exp_exp[rcvd], exp_sm[rcvd]); end
                rcvd++;
            end
            if (in_valid && in_ready) sent++;
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        n_checks++;
        if (rcvd !== 4) begin n_fail++; $display("FAIL b2b_count got %0d want 4", rcvd); end
        n_checks++;
        if (full_seen < 1) begin n_fail++; $display("FAIL b2b_full_backpressure got %0d full cycles want >=1", full_seen); end
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_extra got out_valid=%b want 0", out_valid); end
    endtask

    task automatic test_reset_midflight();
        int stale = 0;
        out_ready = 1'b0;
        @(negedge clk);
        op_a = 32'h3F800000; op_b = 32'h40000000; sub_op = 1'b0; sig2_ge_sig1 = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        op_b = 32'h40800000;
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL midreset got v=%b rdy=%b want 0/1", out_valid, in_ready); end
        n_checks++;
        if (big_sig !== 27'h0 || res_exp !== 8'h0)
            begin n_fail++; $display("FAIL midreset_data got %h/%h want 0/0", big_sig, res_exp); end
        rst_n = 1'b1; out_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        n_checks++;
        if (stale != 0) begin n_fail++; $display("FAIL midreset_stale got %0d results want 0", stale); end
    endtask

    initial begin
        test_reset();
        test_equal_ops();
        test_shift_one();
        test_large_shift();
        test_signs();
        test_special();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_align_stage.md
# fp_align_stage

Two-stage pipelined operand-alignment stage of the FP32 adder. It accepts two packed single-precision operands together with the significand-comparator result `sig2_ge_sig1` for the same pair. It orders the operands so the larger magnitude comes first, and right-shifts the smaller significand by the exponent difference, producing guard/round/sticky bits. Its outputs feed the significand adder/subtractor through a valid/ready handshake.

## Interface
- `EXP_WIDTH`, default 8: exponent field width
- `SIGNIFICANDS_WIDTH`, default 23: fraction field width
- `DATA_WIDTH`, default 32: packed operand width
- `ALIGN_WIDTH`, default 27: hidden bit + fraction + G,R,S
- `clk` in 1: single clock
- `rst_n` in 1: reset; synchronous, active-low
- `in_valid` in 1: operand pair valid
- `in_ready` out 1: stage can accept
- `op_a` in DATA_WIDTH: operand 1 (sign, exp, frac)
- `op_b` in DATA_WIDTH: operand 2
- `sig2_ge_sig1` in 1: comparator result, frac(op_b) >= frac(op_a); combinational on the same-cycle operands
- `sub_op` in 1: 1 means A−B, 0 means A+B
- `out_valid` out 1: result valid
- `out_ready` in 1: downstream accepts
- `big_sig` out ALIGN_WIDTH: larger operand, {hidden, frac, 3'b000}
- `small_sig` out ALIGN_WIDTH: smaller operand, shifted; LSB is sticky
- `res_exp` out EXP_WIDTH: exponent of the larger operand
- `res_sign` out 1: sign of the result before normalisation
- `eff_sub` out 1: effective subtraction
- `swapped` out 1: op_b was larger
- `special` out 1: either exponent all-ones (NaN/Inf)

## Operation
- **Unpack.**
  - hidden = (exp != 0).
  - Effective exponent = exp, or 1 when exp == 0 (denormal).
- **Swap decision.** swap = (exp_b > exp_a) | (exp_b == exp_a & sig2_ge_sig1). The tie case swaps, which is harmless.
- **Result fields.**
  - eff_sub = sign_a ^ sign_b ^ sub_op.
  - res_sign = swap ? (sign_b ^ sub_op) : sign_a.
- **Stage 1** registers:
  - the swapped significands;
  - d = exp_big − exp_small, unsigned 8 bits, always >= 0;
  - res_exp, res_sign, eff_sub, swapped, special.
- **Stage 2** computes small_sig = {sig_small, 3'b000} >> d.
  - The low bit is the OR of all bits shifted out, OR'd with the shifted bit 0.
  - If d >= ALIGN_WIDTH: small_sig = {26'b0, sticky}, where sticky = |sig_small.
- **special:** the operand fields still pass through the normal computation. Downstream handles the NaN/Inf result.
- **Handshake.** A transfer occurs when valid & ready on the same edge.
  - en2 = out_ready | ~s2_valid.
  - en1 = en2 | ~s1_valid.
  - in_ready = en1.
  - Bubbles collapse.
  - Data registers load only on their enable. Held data is stable while out_valid & ~out_ready.

## Timing
- Latency is 2 cycles from input transfer to out_valid, with throughput 1 per cycle when out_ready = 1.
- in_ready is combinational from out_ready and the stage-valid registers. It has no combinational path from in_valid.
- **Reset.** While rst_n = 0 at a clk edge:
  - s1_valid = s2_valid = 0, so out_valid = 0;
  - in_ready = 1;
  - all data outputs = 0.
- A reset mid-operation drops in-flight transactions with no output.
- **Full.** When both stages are valid and out_ready = 0, in_ready = 0 and nothing is overwritten.
- **Simultaneous events.** When out_ready = 1 with both stages full and in_valid = 1, all three transfers happen on the same edge.

## Configuration
- `FP_ALIGN_STICKY_EN` defined: the LSB of small_sig is the sticky OR of the shifted-out bits, as described above.
- `FP_ALIGN_STICKY_EN` undefined: pure truncating shift with no sticky logic. The LSB of small_sig is only the shifted R-position bit, and the d >= ALIGN_WIDTH case yields 0.

## Structure
- **Shared package `fp_pkg`:**
  - width constants (EXP_WIDTH, SIGNIFICANDS_WIDTH, ALIGN_WIDTH);
  - EXP_MAX = 8'hFF;
  - a typedef for the unpacked operand struct {sign, exp, sig}.
- **Sub-module `fp_align_shift`:** combinational barrel right shifter with sticky generation, instantiated in stage 2. The sticky logic is guarded by the macro.

## Test plan
- A = 0x3F800000, B = 0x3F800000, sub_op = 0, sig2_ge_sig1 = 1 -> after 2 cycles: swapped = 1, res_exp = 0x7F, big_sig = small_sig = 0x4000000, eff_sub = 0.
- A = 0x3F800000, B = 0x40000000 -> swapped = 1, res_exp = 0x80, big_sig = 0x4000000, small_sig = 0x2000000.
- A = 0x3F800000, B = 0x4E800000 (d = 30) -> small_sig = 0x0000001 with the macro, 0x0000000 without.
- A = 0xBF800000, B = 0x3F000000, sub_op = 0 -> swapped = 0, eff_sub = 1, res_sign = 1, small_sig = 0x2000000.
- Back-to-back stream of 4 pairs, with out_ready held 0 for 3 cycles after the first result -> in_ready = 0 while both stages are full, outputs held stable, all 4 results delivered in order with none lost.
- rst_n = 0 asserted with 2 transactions in flight -> next cycle out_valid = 0, in_ready = 1, and no stale results appear afterwards.
